tc_mem_model: RTL
=================

Name: tc_mem_model

Overview:
- Cycle-accurate backing-memory stage directly downstream of the tag cache's memory port.
- Consumes the cache's mem_req_cmd / mem_req_data channels and produces mem_resp refill beats from an internal line-organised RAM.
- Used as the memory endpoint in modular tag-cache benches, and as the template for the real memory-side adapter.

Parameters:
ADDR_W, 26, width of mem_req_cmd_addr (line address)
TAG_W, 5, width of request/response tag
DATA_W, 128, beat width
BEATS, 4, beats per cache line (power of two, >=2)
MEM_AW, 10, log2 of lines held; addr bits above MEM_AW-1 are ignored (aliasing)
READ_LAT, 2, idle cycles between read-command acceptance and first response beat (0..15)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
mem_req_cmd_valid  in  1  command valid
mem_req_cmd_ready  out  1  command accepted when valid&ready
mem_req_cmd_addr  in  ADDR_W  line address
mem_req_cmd_tag  in  TAG_W  transaction tag
mem_req_cmd_rw  in  1  1=write line, 0=read line
mem_req_data_valid  in  1  write beat valid
mem_req_data_ready  out  1  write beat accepted when valid&ready
mem_req_data_data  in  DATA_W  write beat payload
mem_resp_valid  out  1  read beat valid; no backpressure, consumer always accepts
mem_resp_data  out  DATA_W  read beat payload
mem_resp_tag  out  TAG_W  tag of the originating read command

Behaviour:
- Reset: asynchronous, active-low. All ready/valid outputs 0; resp_data and resp_tag 0; FSM to IDLE; counters 0.
- RAM contents are not cleared and are X until first written; the bench preloads through a hierarchical task.
- FSM states: IDLE, WRITE, RDWAIT, READ.
- IDLE:
  - cmd_ready=1, data_ready=0.
  - On cmd fire, latch addr[MEM_AW-1:0], tag and rw; clear beat_cnt.
  - rw=1 goes to WRITE.
  - rw=0 goes to RDWAIT, or directly to READ when READ_LAT=0.
- WRITE:
  - cmd_ready=0, data_ready=1.
  - Each data fire writes RAM[line*BEATS+beat_cnt] and increments beat_cnt.
  - The fire with beat_cnt==BEATS-1 returns to IDLE.
  - Gaps in data_valid are allowed and simply stall.
  - Data offered while in IDLE is not accepted. The tag cache issues cmd before or with the first beat; the beat waits for the next cycle.
- RDWAIT: both readies 0. lat_cnt counts READ_LAT-1 down to 0, then goes to READ.
- READ:
  - Issues BEATS synchronous RAM reads on consecutive cycles.
  - resp_valid is registered and asserted for exactly BEATS consecutive cycles.
  - Beat k carries RAM[line*BEATS+k] and the latched tag.
  - Returns to IDLE after the last beat is presented; resp_valid is 0 in the following cycle.
- Latency: for a read cmd accepted at edge T, beat 0 is valid in the cycle after edge T+READ_LAT+1, and beat BEATS-1 follows BEATS-1 cycles later.
- Back-to-back: a new cmd may be accepted in the first IDLE cycle after the previous transaction. Minimum read-to-read spacing is READ_LAT+BEATS+1 cycles.
- resp_data and resp_tag hold their last value while resp_valid=0. Benches must not check them then.
- Reset mid-transaction: FSM returns to IDLE immediately. A partial write leaves already-written beats in RAM. Pending read beats are dropped.
- Address wrap: line index = addr mod 2^MEM_AW; e.g. addr 0x400 aliases line 0 when MEM_AW=10.
- Counters: beat_cnt is log2(BEATS) bits and wraps naturally. lat_cnt is 4 bits.

Decomposition:
- Package tc_mem_pkg holds:
  - default widths ADDR_W, TAG_W, DATA_W, BEATS;
  - typedef mem_state_e {IDLE, WRITE, RDWAIT, READ};
  - typedef mem_cmd_t {addr, tag, rw}.
- One sub-module, tc_mem_ram:
  - single-port, synchronous-read, DATA_W x (2^MEM_AW*BEATS) array;
  - write-enable plus address;
  - read data registered one cycle.
- The FSM, counters and response register live in tc_mem_model.

Test Plan:
- Write then read: write cmd addr=0x3, tag=5, beats 0x11..,0x22..,0x33..,0x44.. -> data_ready high for 4 fires. Read cmd addr=0x3, tag=9 -> resp_valid 4 consecutive cycles starting 3 cycles after cmd fire (READ_LAT=2), data 0x11,0x22,0x33,0x44, tag=9 on every beat.
- Stalled write: beats delivered with 2-cycle gaps -> exactly 4 RAM writes. cmd_ready stays 0 until the 4th beat fires, then is 1 the next cycle.
- Aliasing: write addr=0x401 with pattern A, read addr=0x001 -> returns pattern A (MEM_AW=10).
- READ_LAT=0 build: read cmd accepted at edge T -> beat 0 valid in the cycle after T+1, no RDWAIT visit; back-to-back reads spaced exactly BEATS+1 cycles.
- Reset mid-read: assert reset after beat 1 of a read -> resp_valid drops asynchronously and stays 0. After release, cmd_ready=1 and a fresh read returns all 4 beats with the new tag.
- Early data: data_valid asserted in IDLE together with a write cmd -> data_ready=0 that cycle. The beat is accepted on the next cycle, and beat order in RAM is preserved.

Source files
------------

// File: rtl/tc_mem_pkg.sv
// tc_mem_pkg: shared widths and types for the tag-cache backing-memory model.
// Widths live here so the cache and the memory model always agree on them.
package tc_mem_pkg;

    localparam int ADDR_W = 26;                // line address width
    localparam int TAG_W  = 5;                 // request/response tag width
    localparam int DATA_W = 128;               // beat width
    localparam int BEATS  = 4;                 // beats per line (power of two, >= 2)
    localparam int BEAT_W = $clog2(BEATS);     // beat counter width

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        RDWAIT = 2'd2,
        READ   = 2'd3
    } mem_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [TAG_W-1:0]  tag;
        logic              rw;
    } mem_cmd_t;

endpackage

// File: rtl/tc_mem_ram.sv
// tc_mem_ram: single-port line-organised RAM with synchronous, registered read.
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous active-low reset (clears the read register only)
//   we_i     write enable (wdata_i written to addr_i at the clock edge)
//   re_i     read enable (mem[addr_i] captured into rdata_o at the clock edge)
//   addr_i   word address {line, beat}
//   wdata_i  write data
//   rdata_o  registered read data; holds its value while re_i is low
module tc_mem_ram #(
    parameter int DATA_W = 128,
    parameter int AW     = 12
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    // Array contents are never cleared; unwritten words read as X.
    logic [DATA_W-1:0] mem_q [2**AW];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/tc_mem_model.sv
// tc_mem_model: cycle-accurate backing memory behind the tag cache memory port.
// Accepts line read/write commands, absorbs BEATS write beats per write line,
// and returns BEATS refill beats per read line after READ_LAT idle cycles.
// Handshakes: a command or write beat transfers at a rising edge where both
// its valid and ready are high; valid may be raised at any time and is not
// required to wait for ready. mem_resp has no backpressure: each cycle with
// mem_resp_valid=1 is one beat consumed.
// Ports:
//   clk, reset                       clock, asynchronous active-low reset
//   mem_req_cmd_*                    command channel (addr, tag, rw: 1=write)
//   mem_req_data_*                   write beat channel
//   mem_resp_valid/_data/_tag        read beat channel
//   dbg_state_o                      current FSM state (mem_state_e encoding)
module tc_mem_model
    import tc_mem_pkg::*;
#(
    parameter int MEM_AW   = 10,   // log2 lines held; higher address bits alias
    parameter int READ_LAT = 2     // idle cycles before the first read beat (0..15)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_req_cmd_valid,
    output logic              mem_req_cmd_ready,
    input  logic [ADDR_W-1:0] mem_req_cmd_addr,
    input  logic [TAG_W-1:0]  mem_req_cmd_tag,
    input  logic              mem_req_cmd_rw,
    input  logic              mem_req_data_valid,
    output logic              mem_req_data_ready,
    input  logic [DATA_W-1:0] mem_req_data_data,
    output logic              mem_resp_valid,
    output logic [DATA_W-1:0] mem_resp_data,
    output logic [TAG_W-1:0]  mem_resp_tag,
    output logic [1:0]        dbg_state_o
);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_WRITE  = WRITE;
    localparam logic [1:0] ST_RDWAIT = RDWAIT;
    localparam logic [1:0] ST_READ   = READ;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    logic [1:0]        state_q, state_d;
    mem_cmd_t          cmd_q, cmd_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [3:0]        lat_cnt_q, lat_cnt_d;
    logic              resp_valid_q;
    logic [TAG_W-1:0]  resp_tag_q;

    logic              cmd_fire, data_fire;
    logic              ram_we, ram_re;
    logic [MEM_AW+BEAT_W-1:0] ram_addr;

    // Ready is gated by reset so it is 0 while reset is held, not just after.
    assign mem_req_cmd_ready  = (state_q == ST_IDLE) && reset;
    assign mem_req_data_ready = (state_q == ST_WRITE);
    assign cmd_fire  = mem_req_cmd_valid && mem_req_cmd_ready;
    assign data_fire = mem_req_data_valid && mem_req_data_ready;

    // Line index is the low MEM_AW address bits, beat index below it.
    assign ram_addr = {cmd_q.addr[MEM_AW-1:0], beat_cnt_q};

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        beat_cnt_d = beat_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    cmd_d.addr             = '0;
                    cmd_d.addr[MEM_AW-1:0] = mem_req_cmd_addr[MEM_AW-1:0];
                    cmd_d.tag              = mem_req_cmd_tag;
                    cmd_d.rw               = mem_req_cmd_rw;
                    beat_cnt_d             = '0;
                    if (mem_req_cmd_rw) begin
                        state_d = ST_WRITE;
                    end else if (READ_LAT == 0) begin
                        state_d = ST_READ;
                    end else begin
                        state_d   = ST_RDWAIT;
                        lat_cnt_d = 4'(READ_LAT - 1);
                    end
                end
            end
            ST_WRITE: begin
                if (data_fire) begin
                    ram_we     = 1'b1;
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RDWAIT: begin
                if (lat_cnt_q == 4'd0) begin
                    state_d = ST_READ;
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end
            ST_READ: begin
                // One RAM read per cycle; the data register lands it on the
                // response the following cycle, aligned with resp_valid_q.
                ram_re     = 1'b1;
                beat_cnt_d = beat_cnt_q + 1'b1;
                if (beat_cnt_q == LAST_BEAT) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cmd_q        <= '0;
            beat_cnt_q   <= '0;
            lat_cnt_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_tag_q   <= '0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            beat_cnt_q   <= beat_cnt_d;
            lat_cnt_q    <= lat_cnt_d;
            resp_valid_q <= ram_re;
            if (ram_re) begin
                resp_tag_q <= cmd_q.tag;
            end
        end
    end

    tc_mem_ram #(
        .DATA_W (DATA_W),
        .AW     (MEM_AW + BEAT_W)
    ) u_ram (
        .clk_i   (clk),
        .rst_ni  (reset),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (ram_addr),
        .wdata_i (mem_req_data_data),
        .rdata_o (mem_resp_data)
    );

    assign mem_resp_valid = resp_valid_q;
    assign mem_resp_tag   = resp_tag_q;
    assign dbg_state_o    = state_q;

    // Aliased address bits and the latched rw flag have no further use.
    logic unused_bits;
    assign unused_bits = ^{mem_req_cmd_addr[ADDR_W-1:MEM_AW],
                           cmd_q.addr[ADDR_W-1:MEM_AW], cmd_q.rw};

endmodule
